rvh_l1d_ptw_replay_queue: RTL and testbench

Multi-channel replay holding queue between the page-table walkers and the L1D. It holds one outstanding walk request per PTW ID and re-issues a request after a programmable delay when the store buffer flags a replay. Ready entries are arbitrated round-robin onto a single replay request port. It supersedes the single-entry replay buffer and adds:

- per-ID entries;
- a saturating delay counter;
- grant locking;
- optional exponential backoff.

---
 rtl/rvh_l1d_ptw_replay_queue.sv | 231 +++++++++++++++++++++++
 tb/tb_rvh_l1d_ptw_replay_queue.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rvh_l1d_ptw_replay_queue.sv
// ---------------------------------------------------------------------------
// rvh_l1d_ptw_replay_queue
//
// Replay holding queue between the page-table walkers and the L1D. One entry
// per walker ID holds the outstanding walk request. When the store buffer
// flags a replay for a valid entry, the entry waits a programmable number of
// cycles and then competes round-robin for the single replay request port.
// A grant that is stalled by the L1D (vld without rdy) is locked, so the
// presented ID/address stay stable until the handshake, or until the locked
// entry stops being ready.
//
// Optional feature macro: RVH_L1D_PTW_REPLAY_BACKOFF_EN
//   When defined, each entry's wait doubles after every replay handshake,
//   up to REPLAY_LATENCY << BACKOFF_MAX_SHIFT, and the doubling count is reset
//   on allocation. When undefined, every replay waits REPLAY_LATENCY cycles.
//
// Ports:
//   clk                          clock, all state updates on the rising edge
//   rst                          synchronous reset, active low
//   ptw_walk_req_vld_i/id_i/addr_i
//                                walk request, allocates/overwrites entry id
//   ptw_walk_resp_vld_i/rdy_i/id_i
//                                walk response handshake, clears entry id
//   stb_l1d_ptw_replay_vld_i/id_i
//                                store buffer replay flag for entry id
//   ptw_walk_replay_req_vld_o/id_o/paddr_o
//                                replay request (outputs from registers only)
//   ptw_walk_replay_req_rdy_i    L1D accepts the replay request
// ---------------------------------------------------------------------------
module rvh_l1d_ptw_replay_queue #(
    parameter int PTW_COUNT         = 2,
    parameter int PTW_ID_WIDTH      = 1,
    parameter int PADDR_WIDTH       = 56,
    parameter int REPLAY_LATENCY    = 4,
    parameter int BACKOFF_MAX_SHIFT = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ptw_walk_req_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_req_id_i,
    input  logic [PADDR_WIDTH-1:0]  ptw_walk_req_addr_i,
    input  logic                    ptw_walk_resp_vld_i,
    input  logic                    ptw_walk_resp_rdy_i,
    input  logic [PTW_ID_WIDTH-1:0] ptw_walk_resp_id_i,
    input  logic                    stb_l1d_ptw_replay_vld_i,
    input  logic [PTW_ID_WIDTH-1:0] stb_l1d_ptw_replay_id_i,
    output logic                    ptw_walk_replay_req_vld_o,
    output logic [PTW_ID_WIDTH-1:0] ptw_walk_replay_req_id_o,
    output logic [PADDR_WIDTH-1:0]  ptw_walk_replay_req_paddr_o,
    input  logic                    ptw_walk_replay_req_rdy_i
);

`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
    localparam int MAX_LAT = REPLAY_LATENCY << BACKOFF_MAX_SHIFT;
    localparam int NREP_W  = ($clog2(BACKOFF_MAX_SHIFT + 1) > 2) ? $clog2(BACKOFF_MAX_SHIFT + 1) : 2;
`else
    localparam int MAX_LAT = REPLAY_LATENCY;
`endif
    localparam int DCNT_W  = $clog2(MAX_LAT) + 1;
    localparam int EXP_IDW = (PTW_COUNT > 1) ? $clog2(PTW_COUNT) : 1;

    // Elaboration-time parameter sanity checks.
    if (PTW_ID_WIDTH != EXP_IDW) begin : g_bad_id_width
        $error("PTW_ID_WIDTH must equal max(1, clog2(PTW_COUNT))");
    end
    if (REPLAY_LATENCY < 1) begin : g_bad_latency
        $error("REPLAY_LATENCY must be at least 1");
    end
    if (BACKOFF_MAX_SHIFT < 0) begin : g_bad_shift
        $error("BACKOFF_MAX_SHIFT must not be negative");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PTW_COUNT-1:0]    valid_q;
    logic [PTW_COUNT-1:0]    pending_q;
    logic [DCNT_W-1:0]       dcnt_q   [PTW_COUNT];
    logic [PADDR_WIDTH-1:0]  paddr_q  [PTW_COUNT];
`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
    logic [NREP_W-1:0]       nrep_q   [PTW_COUNT];
`endif
    logic [PTW_ID_WIDTH-1:0] rr_q;
    logic                    lock_vld_q;
    logic [PTW_ID_WIDTH-1:0] lock_id_q;

    // ------------------------------------------------------------------
    // Per-entry terminal count, readiness and event decode
    // ------------------------------------------------------------------
    logic [DCNT_W-1:0]    term_cnt [PTW_COUNT];
    logic [PTW_COUNT-1:0] ready;
    logic [PTW_COUNT-1:0] alloc;
    logic [PTW_COUNT-1:0] clr;
    logic [PTW_COUNT-1:0] flag;
    logic [PTW_COUNT-1:0] grant;

    logic                    arb_vld;
    logic [PTW_ID_WIDTH-1:0] arb_id;
    logic                    lock_hit;
    logic                    sel_vld;
    logic [PTW_ID_WIDTH-1:0] sel_id;
    logic                    hs;

    always_comb begin
        for (int i = 0; i < PTW_COUNT; i++) begin
`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
            term_cnt[i] = DCNT_W'((REPLAY_LATENCY << nrep_q[i]) - 1);
`else
            term_cnt[i] = DCNT_W'(REPLAY_LATENCY - 1);
`endif
            ready[i] = valid_q[i] & pending_q[i] & (dcnt_q[i] == term_cnt[i]);
        end
    end

    // Round-robin pick: first ready index at or after rr_q, modulo PTW_COUNT.
    always_comb begin
        int idx;
        idx     = 0;
        arb_vld = 1'b0;
        arb_id  = '0;
        for (int k = 0; k < PTW_COUNT; k++) begin
            idx = (int'(rr_q) + k) % PTW_COUNT;
            if (!arb_vld && ready[idx]) begin
                arb_vld = 1'b1;
                arb_id  = PTW_ID_WIDTH'(idx);
            end
        end
    end

    // A stalled grant keeps its ID for as long as that entry stays ready;
    // once it stops being ready the arbiter result is used immediately.
    assign lock_hit = lock_vld_q & ready[lock_id_q];
    assign sel_vld  = lock_hit | arb_vld;
    assign sel_id   = lock_hit ? lock_id_q : arb_id;
    assign hs       = sel_vld & ptw_walk_replay_req_rdy_i;

    assign ptw_walk_replay_req_vld_o   = sel_vld;
    assign ptw_walk_replay_req_id_o    = sel_vld ? sel_id : '0;
    assign ptw_walk_replay_req_paddr_o = sel_vld ? paddr_q[sel_id] : '0;

    always_comb begin
        for (int i = 0; i < PTW_COUNT; i++) begin
            alloc[i] = ptw_walk_req_vld_i & (ptw_walk_req_id_i == PTW_ID_WIDTH'(i));
            clr[i]   = ptw_walk_resp_vld_i & ptw_walk_resp_rdy_i
                     & (ptw_walk_resp_id_i == PTW_ID_WIDTH'(i));
            flag[i]  = stb_l1d_ptw_replay_vld_i & valid_q[i]
                     & (stb_l1d_ptw_replay_id_i == PTW_ID_WIDTH'(i));
            grant[i] = hs & (sel_id == PTW_ID_WIDTH'(i));
        end
    end

    // ------------------------------------------------------------------
    // Entry control state. Event priority: alloc > clear > flag > grant >
    // count. A flag in the same cycle as this entry's grant restarts the wait.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            valid_q   <= '0;
            pending_q <= '0;
            for (int i = 0; i < PTW_COUNT; i++) begin
                dcnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PTW_COUNT; i++) begin
                if (alloc[i]) begin
                    valid_q[i]   <= 1'b1;
                    pending_q[i] <= 1'b0;
                    dcnt_q[i]    <= '0;
                end else if (clr[i]) begin
                    valid_q[i]   <= 1'b0;
                    pending_q[i] <= 1'b0;
                    dcnt_q[i]    <= '0;
                end else if (flag[i]) begin
                    pending_q[i] <= 1'b1;
                    dcnt_q[i]    <= '0;
                end else if (grant[i]) begin
                    pending_q[i] <= 1'b0;
                    dcnt_q[i]    <= '0;
                end else if (valid_q[i] && pending_q[i] && (dcnt_q[i] < term_cnt[i])) begin
                    dcnt_q[i]    <= dcnt_q[i] + DCNT_W'(1);
                end
            end
        end
    end

    // Payload is only observed while the entry is valid, so it needs no reset.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PTW_COUNT; i++) begin
            if (alloc[i]) begin
                paddr_q[i] <= ptw_walk_req_addr_i;
            end
        end
    end

`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < PTW_COUNT; i++) begin
                nrep_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < PTW_COUNT; i++) begin
                if (alloc[i]) begin
                    nrep_q[i] <= '0;
                end else if (!clr[i] && !flag[i] && grant[i]
                             && (nrep_q[i] < NREP_W'(BACKOFF_MAX_SHIFT))) begin
                    nrep_q[i] <= nrep_q[i] + NREP_W'(1);
                end
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Arbiter pointer and grant lock
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_q       <= '0;
            lock_vld_q <= 1'b0;
            lock_id_q  <= '0;
        end else begin
            lock_vld_q <= sel_vld & ~ptw_walk_replay_req_rdy_i;
            lock_id_q  <= sel_id;
            if (hs) begin
                rr_q <= (sel_id == PTW_ID_WIDTH'(PTW_COUNT - 1)) ? '0 : sel_id + PTW_ID_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_rvh_l1d_ptw_replay_queue.sv
// ---------------------------------------------------------------------------
// Testbench for rvh_l1d_ptw_replay_queue.
// A directed vector table, hand-written corner sequences and a randomized
// phase, all cross-checked against a timestamp-based reference model.
// ---------------------------------------------------------------------------
module tb_rvh_l1d_ptw_replay_queue;
    localparam int N   = 2;
    localparam int IW  = 1;
    localparam int AW  = 56;
    localparam int LAT = 4;
    localparam int BMS = 3;
    localparam int NV  = 43;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_vld;
    logic [IW-1:0] req_id;
    logic [AW-1:0] req_addr;
    logic          resp_vld;
    logic          resp_rdy;
    logic [IW-1:0] resp_id;
    logic          stb_vld;
    logic [IW-1:0] stb_id;
    logic          rep_vld;
    logic [IW-1:0] rep_id;
    logic [AW-1:0] rep_paddr;
    logic          rep_rdy;

    always #5 clk = ~clk;

    rvh_l1d_ptw_replay_queue #(
        .PTW_COUNT(N), .PTW_ID_WIDTH(IW), .PADDR_WIDTH(AW),
        .REPLAY_LATENCY(LAT), .BACKOFF_MAX_SHIFT(BMS)
    ) dut (
        .clk(clk), .rst(rst),
        .ptw_walk_req_vld_i(req_vld), .ptw_walk_req_id_i(req_id), .ptw_walk_req_addr_i(req_addr),
        .ptw_walk_resp_vld_i(resp_vld), .ptw_walk_resp_rdy_i(resp_rdy), .ptw_walk_resp_id_i(resp_id),
        .stb_l1d_ptw_replay_vld_i(stb_vld), .stb_l1d_ptw_replay_id_i(stb_id),
        .ptw_walk_replay_req_vld_o(rep_vld), .ptw_walk_replay_req_id_o(rep_id),
        .ptw_walk_replay_req_paddr_o(rep_paddr), .ptw_walk_replay_req_rdy_i(rep_rdy)
    );

    int total = 0;
    int bad   = 0;
    bit last_vld;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // An entry replays once enough edges have passed since its flag edge.
    bit            m_valid [N];
    bit            m_pend  [N];
    int            m_flag_e[N];
    logic [AW-1:0] m_addr  [N];
    int            m_nrep  [N];
    int            m_rr;
    bit            m_lock;
    int            m_lock_id;
    int            m_edge = 0;

    function automatic int lat_of(input int i);
`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
        return LAT << m_nrep[i];
`else
        return LAT + 0 * m_nrep[i];
`endif
    endfunction

    function automatic bit m_ready(input int i);
        return m_valid[i] && m_pend[i] && (m_edge - m_flag_e[i] >= lat_of(i) - 1);
    endfunction

    task automatic m_out(output bit v, output int id);
        int j;
        v  = 1'b0;
        id = 0;
        if (m_lock && m_ready(m_lock_id)) begin
            v  = 1'b1;
            id = m_lock_id;
        end else begin
            for (int k = 0; k < N; k++) begin
                j = (m_rr + k) % N;
                if (!v && m_ready(j)) begin
                    v  = 1'b1;
                    id = j;
                end
            end
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < N; i++) begin
            m_valid[i] = 0; m_pend[i] = 0; m_nrep[i] = 0; m_flag_e[i] = 0;
        end
        m_rr = 0; m_lock = 0; m_lock_id = 0;
    endtask

    task automatic m_step();
        bit v;
        int id;
        bit hs;
        m_out(v, id);
        hs = v && rep_rdy;
        if (!rst) begin
            m_reset();
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_vld && int'(req_id) == i) begin
                    m_valid[i] = 1; m_pend[i] = 0; m_nrep[i] = 0; m_addr[i] = req_addr;
                end else if (resp_vld && resp_rdy && int'(resp_id) == i) begin
                    m_valid[i] = 0; m_pend[i] = 0;
                end else if (stb_vld && int'(stb_id) == i && m_valid[i]) begin
                    m_pend[i] = 1; m_flag_e[i] = m_edge + 1;
                end else if (hs && id == i) begin
                    m_pend[i] = 0;
                    if (m_nrep[i] < BMS) m_nrep[i]++;
                end
            end
            m_lock    = v && !rep_rdy;
            m_lock_id = id;
            if (hs) m_rr = (id + 1) % N;
        end
        m_edge++;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          req_vld;
        logic [IW-1:0] req_id;
        logic [AW-1:0] req_addr;
        logic          resp_vld;
        logic [IW-1:0] resp_id;
        logic          stb_vld;
        logic [IW-1:0] stb_id;
        logic          rdy;
        logic          exp_vld;
        logic [IW-1:0] exp_id;
        logic [AW-1:0] exp_paddr;
    } vec_t;

    vec_t tab[NV];

    task automatic t_alloc(input int r, input int id, input logic [AW-1:0] a);
        tab[r].req_vld = 1; tab[r].req_id = IW'(id); tab[r].req_addr = a;
    endtask
    task automatic t_flag(input int r, input int id);
        tab[r].stb_vld = 1; tab[r].stb_id = IW'(id);
    endtask
    task automatic t_resp(input int r, input int id);
        tab[r].resp_vld = 1; tab[r].resp_id = IW'(id);
    endtask
    task automatic t_exp(input int r, input int id, input logic [AW-1:0] a);
        tab[r].exp_vld = 1; tab[r].exp_id = IW'(id); tab[r].exp_paddr = a;
    endtask

    task automatic set_idle();
        rst = 1; req_vld = 0; req_id = 0; req_addr = 0;
        resp_vld = 0; resp_rdy = 0; resp_id = 0;
        stb_vld = 0; stb_id = 0; rep_rdy = 1;
    endtask

    // One clock: compare DUT outputs with the model (and optionally a table
    // row) at the falling edge, advance the model, then cross the rising edge.
    task automatic cycle(input string tag, input bit use_tab, input vec_t e);
        bit v;
        int id;
        @(negedge clk);
        m_out(v, id);
        last_vld = rep_vld;
        chk($sformatf("%s model vld_o", tag), 64'(rep_vld), 64'(v));
        chk($sformatf("%s model id_o", tag), 64'(rep_id), v ? 64'(id) : 64'(0));
        chk($sformatf("%s model paddr_o", tag), 64'(rep_paddr), v ? 64'(m_addr[id]) : 64'(0));
        if (use_tab) begin
            chk($sformatf("%s vld_o", tag), 64'(rep_vld), 64'(e.exp_vld));
            chk($sformatf("%s id_o", tag), 64'(rep_id), 64'(e.exp_id));
            chk($sformatf("%s paddr_o", tag), 64'(rep_paddr), 64'(e.exp_paddr));
        end
        m_step();
        @(posedge clk);
        #1;
    endtask

    vec_t none;
    int   n;
    bit   seen;

    initial begin
        none = '{default: '0};
        for (int i = 0; i < NV; i++) begin
            tab[i] = '{default: '0};
            tab[i].rdy = 1;
        end
        // base latency
        t_alloc(0, 0, 56'h12345);
        t_flag(1, 0);
        t_exp(5, 0, 56'h12345);
        // both entries pending, first grant stalled one cycle
        t_alloc(6, 1, 56'hABCDE);
        t_flag(7, 0);
        t_flag(8, 1);
        tab[11].rdy = 0;
        t_exp(11, 0, 56'h12345);
        t_exp(12, 0, 56'h12345);
        t_exp(13, 1, 56'hABCDE);
        // grant lock: id1 held while id0 becomes ready underneath
        t_flag(14, 1);
        t_flag(16, 0);
        for (int r = 18; r <= 22; r++) begin
            tab[r].rdy = 0;
            t_exp(r, 1, 56'hABCDE);
        end
        t_exp(23, 1, 56'hABCDE);
        t_exp(24, 0, 56'h12345);
        // response clear while ready
        t_flag(25, 0);
        t_resp(29, 0);
        tab[29].rdy = 0;
        t_exp(29, 0, 56'h12345);
        // alloc + resp on the same id, then a flag on an invalid entry
        t_alloc(31, 1, 56'h55555);
        t_resp(31, 1);
        t_flag(32, 1);
        t_exp(36, 1, 56'h55555);
        t_flag(37, 0);

        set_idle();
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        m_reset();
        rst = 1;
        chk("reset vld_o", 64'(rep_vld), 64'(0));
        chk("reset id_o", 64'(rep_id), 64'(0));
        chk("reset paddr_o", 64'(rep_paddr), 64'(0));

        for (int r = 0; r < NV; r++) begin
            req_vld = tab[r].req_vld; req_id = tab[r].req_id; req_addr = tab[r].req_addr;
            resp_vld = tab[r].resp_vld; resp_rdy = tab[r].resp_vld; resp_id = tab[r].resp_id;
            stb_vld = tab[r].stb_vld; stb_id = tab[r].stb_id; rep_rdy = tab[r].rdy;
            cycle($sformatf("row%0d", r), 1'b1, tab[r]);
        end

        // randomized phase
        for (int c = 0; c < 3000; c++) begin
            rst      = ($urandom_range(0, 199) != 0);
            req_vld  = ($urandom_range(0, 9) == 0);
            req_id   = IW'($urandom_range(0, N - 1));
            req_addr = AW'({$urandom(), $urandom()});
            resp_vld = ($urandom_range(0, 9) == 0);
            resp_rdy = ($urandom_range(0, 3) != 0);
            resp_id  = IW'($urandom_range(0, N - 1));
            stb_vld  = ($urandom_range(0, 4) == 0);
            stb_id   = IW'($urandom_range(0, N - 1));
            rep_rdy  = ($urandom_range(0, 9) < 6);
            cycle("rand", 1'b0, none);
        end

        // repeated replay rounds on one entry: delay per round
        set_idle();
        rst = 0;
        cycle("bo reset", 1'b0, none);
        set_idle();
        req_vld = 1; req_id = 0; req_addr = 56'h3C3C3;
        cycle("bo alloc", 1'b0, none);
        for (int r = 0; r < 5; r++) begin
            set_idle();
            stb_vld = 1; stb_id = 0;
            cycle("bo flag", 1'b0, none);
            set_idle();
            n = 0;
            do begin
                n++;
                cycle("bo wait", 1'b0, none);
            end while (!last_vld && n < 100);
`ifdef RVH_L1D_PTW_REPLAY_BACKOFF_EN
            chk($sformatf("backoff delay round %0d", r), 64'(n), 64'(LAT << ((r < BMS) ? r : BMS)));
`else
            chk($sformatf("replay delay round %0d", r), 64'(n), 64'(LAT));
`endif
        end

        // reset in the middle of a countdown
        set_idle();
        req_vld = 1; req_id = 0; req_addr = 56'h777;
        cycle("mid alloc", 1'b0, none);
        set_idle();
        stb_vld = 1; stb_id = 0;
        cycle("mid flag", 1'b0, none);
        set_idle();
        cycle("mid cnt0", 1'b0, none);
        cycle("mid cnt1", 1'b0, none);
        rst = 0;
        cycle("mid reset", 1'b0, none);
        set_idle();
        chk("mid reset vld_o", 64'(rep_vld), 64'(0));
        chk("mid reset id_o", 64'(rep_id), 64'(0));
        chk("mid reset paddr_o", 64'(rep_paddr), 64'(0));
        stb_vld = 1; stb_id = 0;
        cycle("mid stale flag", 1'b0, none);
        set_idle();
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            cycle("mid idle", 1'b0, none);
            seen = seen | last_vld;
        end
        chk("no replay after reset", 64'(seen), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
